// File: rtl/lfsr_rng_gen.sv
// Fibonacci LFSR random-number source with programmable taps, runtime reseed,
// a fixed-latency draw FSM and a wrap pulse marking each return to the start value.
module lfsr_rng_gen #(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS  = 4'b1100,
    parameter logic [WIDTH-1:0] SEED  = '1,
    parameter int               OUT_W = WIDTH,
    parameter int               STEPS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rng_gen,
    input  logic             seed_ld,
    input  logic [WIDTH-1:0] seed_in,
    output logic [OUT_W-1:0] count_out,
    output logic             en,
    output logic             busy,
    output logic [WIDTH-1:0] lfsr_q,
    output logic             wrap
);

    localparam logic [7:0] STEPS_C = 8'(STEPS);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state_q;
    logic [7:0]       cnt_q;
    logic [WIDTH-1:0] start_q;

    logic             fb;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] lfsr_d;
    logic [WIDTH-1:0] start_d;
    logic             wrap_d;

    // Next LFSR state: reseed wins over stepping; an all-zero value falls back to SEED.
    always_comb begin
        fb       = ^(lfsr_q & TAPS);
        step_val = {lfsr_q[WIDTH-2:0], fb};
        start_d  = start_q;
        if (seed_ld) begin
            lfsr_d  = (seed_in == '0) ? SEED : seed_in;
            start_d = lfsr_d;
        end else begin
            lfsr_d  = (step_val == '0) ? SEED : step_val;
        end
        wrap_d = !seed_ld && (lfsr_d == start_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q    <= SEED;
            start_q   <= SEED;
            wrap      <= 1'b0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            count_out <= '0;
            en        <= 1'b0;
            busy      <= 1'b0;
        end else begin
            lfsr_q  <= lfsr_d;
            start_q <= start_d;
            wrap    <= wrap_d;
            en      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rng_gen) begin
                        state_q <= RUN;
                        cnt_q   <= STEPS_C;
                        busy    <= 1'b1;
                    end
                end
                RUN: begin
                    // Capture the value the LFSR takes on the same edge the counter hits zero.
                    cnt_q <= cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        count_out <= lfsr_d[OUT_W-1:0];
                        en        <= 1'b1;
                        busy      <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_rng_gen.sv
// Directed bench for lfsr_rng_gen: default 4-bit build plus an 8-bit, STEPS=1 build.
module tb_lfsr_rng_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rng_gen = 1'b0;
    logic       seed_ld = 1'b0;
    logic [3:0] seed_in = 4'h0;
    logic [3:0] count_out;
    logic       en, busy, wrap;
    logic [3:0] lfsr_q;

    logic       rst2 = 1'b1;
    logic       rng_gen2 = 1'b0;
    logic [2:0] count_out2;
    logic       en2, busy2, wrap2;
    logic [7:0] lfsr_q2;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    lfsr_rng_gen dut (
        .clk(clk), .rst(rst), .rng_gen(rng_gen), .seed_ld(seed_ld), .seed_in(seed_in),
        .count_out(count_out), .en(en), .busy(busy), .lfsr_q(lfsr_q), .wrap(wrap)
    );

    lfsr_rng_gen #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'hFF), .OUT_W(3), .STEPS(1)) dut8 (
        .clk(clk), .rst(rst2), .rng_gen(rng_gen2), .seed_ld(1'b0), .seed_in(8'h00),
        .count_out(count_out2), .en(en2), .busy(busy2), .lfsr_q(lfsr_q2), .wrap(wrap2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] seq [15] = '{4'hE, 4'hC, 4'h8, 4'h1, 4'h2, 4'h4, 4'h9, 4'h3,
                             4'h6, 4'hD, 4'hA, 4'h5, 4'hB, 4'h7, 4'hF};
    logic       req_pat [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        int         en_cnt;
        logic [7:0] m;

        // Reset held for two edges
        tick();
        tick();
        chk("rst_lfsr", 32'(lfsr_q), 32'hF);
        chk("rst_cnt_out", 32'(count_out), 32'h0);
        chk("rst_en", 32'(en), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_wrap", 32'(wrap), 32'h0);
        rst = 1'b0;

        // Single draw: accepted on edge 1, captured on edge 5
        rng_gen = 1'b1;
        tick();
        rng_gen = 1'b0;
        chk("draw_first_lfsr", 32'(lfsr_q), 32'hE);
        chk("draw_busy_e1", 32'(busy), 32'h1);
        for (int k = 2; k <= 4; k++) begin
            tick();
            chk("draw_busy_mid", 32'(busy), 32'h1);
            chk("draw_en_mid", 32'(en), 32'h0);
        end
        tick();
        chk("draw_cnt_out", 32'(count_out), 32'h2);
        chk("draw_en", 32'(en), 32'h1);
        chk("draw_busy_done", 32'(busy), 32'h0);
        chk("draw_lfsr_e5", 32'(lfsr_q), 32'h2);
        tick();
        chk("draw_en_drop", 32'(en), 32'h0);
        chk("draw_cnt_hold", 32'(count_out), 32'h2);

        // Free-running period and wrap over two full periods
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            chk("period_lfsr", 32'(lfsr_q), 32'(seq[(k - 1) % 15]));
            chk("period_wrap", 32'(wrap), 32'((k % 15) == 0));
        end

        // Reseed with 0110, wrap 15 steps after the load
        seed_in = 4'h6;
        seed_ld = 1'b1;
        tick();
        seed_ld = 1'b0;
        chk("reseed_lfsr", 32'(lfsr_q), 32'h6);
        chk("reseed_wrap", 32'(wrap), 32'h0);
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (k == 1) chk("reseed_step1", 32'(lfsr_q), 32'hD);
            chk("reseed_wrap_k", 32'(wrap), 32'(k == 15));
        end
        chk("reseed_return", 32'(lfsr_q), 32'h6);

        // Zero reseed falls back to SEED
        seed_in = 4'h0;
        seed_ld = 1'b1;
        tick();
        seed_ld = 1'b0;
        chk("reseed_zero", 32'(lfsr_q), 32'hF);

        // Requests while busy are ignored; exactly one en
        en_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            rng_gen = req_pat[k];
            tick();
            if (en) en_cnt++;
            if (k == 4) begin
                chk("ign_cnt_out", 32'(count_out), 32'h2);
                chk("ign_en", 32'(en), 32'h1);
                chk("ign_busy", 32'(busy), 32'h0);
            end
        end
        rng_gen = 1'b0;
        chk("ign_en_count", 32'(en_cnt), 32'h1);

        // Back-to-back: rng_gen held high, one capture every STEPS+1 edges
        rng_gen = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (k == 15) rng_gen = 1'b0;
            chk("b2b_en", 32'(en), 32'((k % 5) == 0));
        end

        // Reset two edges into a draw discards it
        rng_gen = 1'b1;
        tick();
        rng_gen = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_en", 32'(en), 32'h0);
        chk("midrst_cnt_out", 32'(count_out), 32'h0);
        en_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (en) en_cnt++;
        end
        chk("midrst_no_en", 32'(en_cnt), 32'h0);
        chk("midrst_cnt_hold", 32'(count_out), 32'h0);

        // 8-bit build: period 255, STEPS=1 draws with rng_gen held high
        rst2 = 1'b1;
        tick();
        rst2 = 1'b0;
        chk("w8_rst_lfsr", 32'(lfsr_q2), 32'hFF);
        m = 8'hFF;
        rng_gen2 = 1'b1;
        for (int k = 1; k <= 255; k++) begin
            tick();
            m = {m[6:0], ^(m & 8'hB8)};
            chk("w8_lfsr", 32'(lfsr_q2), 32'(m));
            chk("w8_wrap", 32'(wrap2), 32'(k == 255));
            chk("w8_en", 32'(en2), 32'((k % 2) == 0));
            if ((k % 2) == 0) chk("w8_cnt_out", 32'(count_out2), 32'(m[2:0]));
        end
        rng_gen2 = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/lfsr_rng_gen.md
# lfsr_rng_gen

Parametrised pseudo-random number generator for the scrambler datapath: a WIDTH-bit Fibonacci LFSR with programmable tap mask, reset seed and runtime reseed. A one-cycle request starts a draw. After a fixed STEPS-cycle decorrelation delay, the block returns an OUT_W-bit value with a one-cycle valid strobe. It also flags each time the sequence returns to its starting value, so the period can be checked in-system.

## Interface
- WIDTH, 4: LFSR length in bits, 4..32.
- TAPS, 4'b1100: feedback tap mask, WIDTH bits; bit i set means state[i] enters the XOR feedback.
- SEED, all ones: reset/fallback state, WIDTH bits, must be nonzero.
- OUT_W, WIDTH: width of the returned value, 1..WIDTH.
- STEPS, 4: LFSR advances between request acceptance and capture, 1..255.
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- rng_gen  in  1  draw request, sampled each edge.
- seed_ld  in  1  load seed_in into the LFSR this edge.
- seed_in  in  WIDTH  reseed value.
- count_out  out  OUT_W  last captured random value.
- en  out  1  one-cycle strobe: count_out updated.
- busy  out  1  draw in progress; rng_gen ignored while high.
- lfsr_q  out  WIDTH  current LFSR state.
- wrap  out  1  one-cycle pulse: LFSR stepped back onto its start value.

## Operation
- Reset: the edge with rst=1 sets lfsr_q=SEED, start value=SEED, count_out=0, en=0, busy=0, wrap=0, step counter=0. Reset overrides every other input.
- Stepping: every edge without rst or seed_ld computes fb = ^(lfsr_q & TAPS) and sets lfsr_q <= {lfsr_q[WIDTH-2:0], fb}. The LFSR is free-running and is never held.
- Zero guard: if the loaded value or the computed next state is all zeros, lfsr_q <= SEED instead.
- Reseed: seed_ld=1 sets lfsr_q <= seed_in, or SEED if seed_in==0, and records that value as the new start value. Reseed has priority over stepping. Reseed does not abort a draw in progress; the step counter keeps running.
- wrap: set to 1 for the cycle after an edge on which stepping (not reseed) produced the start value. It is 0 otherwise.
- Draw FSM, two states:
  - IDLE (busy=0): rng_gen=1 at an edge moves to RUN and loads the counter with STEPS.
  - RUN (busy=1): the counter decrements once per edge. On the edge where it reaches 0:
    - count_out <= next lfsr_q[OUT_W-1:0], the same value lfsr_q takes at that edge;
    - en=1 for the following cycle;
    - return to IDLE.
  - rng_gen in RUN, including the completing edge, is ignored. No queuing.
- en is 0 except for that single cycle. count_out holds its value between draws.

## Timing
- Request accepted at edge E: busy=1 after E; count_out, en=1 and busy=0 after edge E+STEPS. Latency is STEPS cycles.
- Back-to-back draws: rng_gen held high gives one accepted request every STEPS+1 edges.
- A draw accepted in the same cycle en is high is legal; busy rises on that edge.
- Period with the default TAPS/WIDTH (x^4+x^3+1) is 15. The sequence from 1111 is: 1110, 1100, 1000, 0001, 0010, 0100, 1001, 0011, 0110, 1101, 1010, 0101, 1011, 0111, 1111.
- rst asserted mid-draw: on that edge busy=0, en=0, count_out=0, and the draw is discarded.

## Test plan
- Reset: rst=1 for 2 cycles, then release -> lfsr_q=1111, count_out=0, en=0, busy=0, wrap=0. First free edge gives lfsr_q=1110.
- Single draw, defaults: rng_gen=1 on edge 1 after reset release -> busy high for edges 2..5; after edge 5, count_out=0010, en=1 for one cycle, busy=0.
- Period/wrap: run free with defaults -> wrap pulses exactly every 15 cycles, first after edge 15 (lfsr_q=1111). lfsr_q never equals 0000.
- Reseed: seed_ld=1, seed_in=0110 -> lfsr_q=0110, then 1101 next edge, and wrap 15 edges after the load. seed_in=0000 -> lfsr_q=1111.
- Request during busy and reset mid-draw: rng_gen pulses while busy=1 -> ignored, exactly one en. rst=1 two edges into a draw -> busy=0, en never pulses, count_out=0.
- Parametrised build WIDTH=8, TAPS=8'hB8, OUT_W=3, STEPS=1 -> period 255. count_out equals lfsr_q[2:0] at the capture edge, and en follows each accepted rng_gen by 1 cycle.
